// File: rtl/capp_search_engine.sv
// rtl/capp_search_engine.sv - content-addressable word array with masked search, delete and ascending result stream
// Optional feature macro CAPP_MATCH_COUNT_EN adds the match_count popcount output.
module capp_search_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] comparand,
  input  logic [WIDTH-1:0] mask,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_addr,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic             done,
`ifdef CAPP_MATCH_COUNT_EN
  output logic [AW:0]      match_count,
`endif
  output logic             some,
  output logic             none
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EMIT, S_FIN} state_t;

  localparam logic [1:0]       OP_FIRST  = 2'b01;
  localparam logic [1:0]       OP_DELETE = 2'b10;
  localparam logic [DEPTH-1:0] ONE       = DEPTH'(1);
  localparam logic [AW:0]      DEPTH_W   = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] cmp_q, cmp_d, mask_q, mask_d;
  logic [DEPTH-1:0] tags_q, tags_d, valid_q, valid_d, match;
  logic             some_q, some_d, none_q, none_d;
  logic [WIDTH-1:0] words_q [DEPTH];
  logic [WIDTH-1:0] words_d [DEPTH];
  logic             wr_hit;

  assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_W);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (((words_q[i] ^ cmp_q) & mask_q) == '0);
    end
  end

  // Lowest set tag wins; with no tags this falls back to address 0.
  always_comb begin
    res_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags_q[i]) res_addr = AW'(i);
    end
  end

  assign res_data  = words_q[res_addr];
  assign res_last  = (state_q == S_EMIT) && ((tags_q & (tags_q - ONE)) == '0);
  assign some      = some_q;
  assign none      = none_q;

`ifdef CAPP_MATCH_COUNT_EN
  logic [AW:0] match_count_q, match_count_d, match_pop;

  always_comb begin
    match_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_pop = match_pop + (AW+1)'(match[i]);
    end
  end

  assign match_count = match_count_q;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cmp_d     = cmp_q;
    mask_d    = mask_q;
    tags_d    = tags_q;
    valid_d   = valid_q;
    some_d    = some_q;
    none_d    = none_q;
    words_d   = words_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
`ifdef CAPP_MATCH_COUNT_EN
    match_count_d = match_count_q;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          cmp_d   = comparand;
          mask_d  = mask;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        tags_d = match;
        some_d = |match;
        none_d = ~|match;
`ifdef CAPP_MATCH_COUNT_EN
        match_count_d = match_pop;
`endif
        if (match == '0) begin
          state_d = S_FIN;
        end else if (op_q == OP_DELETE) begin
          valid_d = valid_q & ~match;
          tags_d  = '0;
          state_d = S_FIN;
        end else if (op_q == OP_FIRST) begin
          tags_d  = match & (~match + ONE);
          state_d = S_EMIT;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          tags_d = tags_q & (tags_q - ONE);
          if (res_last) state_d = S_FIN;
        end
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Applied after the delete so a same-cycle write keeps its word valid.
    if (wr_hit) begin
      words_d[wr_addr] = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cmp_q   <= '0;
      mask_q  <= '0;
      tags_q  <= '0;
      valid_q <= '0;
      some_q  <= 1'b0;
      none_q  <= 1'b1;
`ifdef CAPP_MATCH_COUNT_EN
      match_count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cmp_q   <= cmp_d;
      mask_q  <= mask_d;
      tags_q  <= tags_d;
      valid_q <= valid_d;
      some_q  <= some_d;
      none_q  <= none_d;
`ifdef CAPP_MATCH_COUNT_EN
      match_count_q <= match_count_d;
`endif
    end
  end

  // Word contents survive reset; only the write is suppressed.
  always_ff @(posedge CLK) begin
    if (!RST) words_q <= words_d;
  end

endmodule

// File: tb/tb_capp_search_engine.sv
// tb/tb_capp_search_engine.sv - self-checking bench with a transaction-level CAM model
module tb_capp_search_engine;
  localparam int WIDTH = 32;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic             clk = 1'b0;
  logic             RST, wr_en, cmd_valid, res_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data, comparand, mask;
  logic [1:0]       cmd_op;
  logic             cmd_ready, res_valid, res_last, done, some, none;
  logic [AW-1:0]    res_addr;
  logic [WIDTH-1:0] res_data;
`ifdef CAPP_MATCH_COUNT_EN
  logic [AW:0]      match_count;
`endif

  always #5 clk = ~clk;

  capp_search_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .comparand(comparand), .mask(mask), .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_data(res_data), .res_last(res_last), .done(done),
`ifdef CAPP_MATCH_COUNT_EN
    .match_count(match_count),
`endif
    .some(some), .none(none)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: array contents, pending result queue and command progress flags.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_vld [DEPTH];
  int               m_q[$];
  bit               m_busy, m_done_due, m_search_pend, m_some, m_none;
  logic [1:0]       m_op;
  logic [WIDTH-1:0] m_cmp, m_msk;
  int               m_cnt;
  int               got[$];

  always @(posedge clk) begin : model
    int hits[$];
    bit dd, acc;
    if (RST) begin
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      m_q.delete();
      m_busy = 0; m_done_due = 0; m_search_pend = 0;
      m_some = 0; m_none = 1; m_cnt = 0;
    end else begin
      dd  = 0;
      acc = cmd_valid && !m_busy;
      if (m_done_due) m_busy = 0;
      if (m_q.size() > 0 && res_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) dd = 1;
      end
      if (m_search_pend) begin
        hits.delete();
        for (int i = 0; i < DEPTH; i++)
          if (m_vld[i] && ((m_mem[i] ^ m_cmp) & m_msk) == 0) hits.push_back(i);
        m_cnt  = hits.size();
        m_some = (hits.size() != 0);
        m_none = !m_some;
        if (hits.size() == 0) dd = 1;
        else if (m_op == 2'b10) begin
          foreach (hits[k]) m_vld[hits[k]] = 1'b0;
          dd = 1;
        end else if (m_op == 2'b01) m_q.push_back(hits[0]);
        else m_q = hits;
        m_search_pend = 0;
      end
      if (wr_en && wr_addr < DEPTH) begin
        m_mem[wr_addr] = wr_data;
        m_vld[wr_addr] = 1'b1;
      end
      if (acc) begin
        m_busy = 1; m_search_pend = 1;
        m_op = cmd_op; m_cmp = comparand; m_msk = mask;
      end
      m_done_due = dd;
    end
  end

  always @(negedge clk) begin : compare
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("res_valid", res_valid, m_q.size() > 0);
    chk("done", done, m_done_due);
    chk("some", some, m_some);
    chk("none", none, m_none);
`ifdef CAPP_MATCH_COUNT_EN
    chk("match_count", match_count, m_cnt);
`endif
    if (m_q.size() > 0) begin
      chk("res_addr", res_addr, m_q[0]);
      chk("res_last", res_last, m_q.size() == 1);
      chk("res_data", res_data, m_mem[m_q[0]]);
    end else begin
      chk("res_addr_idle", res_addr, 0);
      chk("res_last_idle", res_last, 0);
    end
    if (res_valid && res_ready) got.push_back(int'(res_addr));
  end

  function automatic int g(input int i);
    return (got.size() > i) ? got[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    int b = 0;
    while (!cmd_ready && b < 300) begin tick(); b++; end
    if (b >= 300) chk("issue_timeout", 0, 1);
    got.delete();
    cmd_valid = 1'b1; cmd_op = op; comparand = c; mask = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input bit rnd);
    cyc = 0;
    for (int b = 0; b < 400; b++) begin
      tick();
      cyc++;
      if (done) break;
      if (rnd) begin
        res_ready = 1'($urandom_range(0, 1));
        wr_en     = ($urandom_range(0, 3) == 0);
        wr_addr   = AW'($urandom_range(0, DEPTH + 9));
        wr_data   = $urandom_range(0, 7);
      end
    end
    wr_en = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    logic [WIDTH-1:0] mk;
    RST = 1; wr_en = 0; wr_addr = '0; wr_data = '0; cmd_valid = 0; cmd_op = '0;
    comparand = '0; mask = '0; res_ready = 0;
    repeat (3) tick();
    RST = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_none", none, 1);
    chk("rst_some", some, 0);

    write(3, 5); write(7, 5); write(9, 4);
    res_ready = 1;
    issue(2'b00, 5, 5); wait_done(cyc, 0);
    chk("t1_count", got.size(), 2);
    chk("t1_a0", g(0), 3);
    chk("t1_a1", g(1), 7);
    chk("t1_done_cyc", cyc, 3);
    chk("t1_some", some, 1);

    issue(2'b01, 5, '1); wait_done(cyc, 0);
    chk("t2_count", got.size(), 1);
    chk("t2_a0", g(0), 3);
    chk("t2_done_cyc", cyc, 2);

    issue(2'b10, 5, '1); wait_done(cyc, 0);
    chk("t3_del_count", got.size(), 0);
    chk("t3_del_cyc", cyc, 1);
`ifdef CAPP_MATCH_COUNT_EN
    chk("t3_match_count", match_count, 2);
`endif
    issue(2'b00, 0, 0); wait_done(cyc, 0);
    chk("t3_count", got.size(), 1);
    chk("t3_a0", g(0), 9);

    issue(2'b00, 32'hDEAD, 32'hFFFF); wait_done(cyc, 0);
    chk("t4_count", got.size(), 0);
    chk("t4_done_cyc", cyc, 1);
    chk("t4_none", none, 1);

    write(3, 5); write(7, 5);
    res_ready = 0;
    issue(2'b00, 5, '1);
    tick();
    chk("t5_addr0", res_addr, 3);
    chk("t5_data0", res_data, 5);
    wr_en = 1; wr_addr = 3; wr_data = 32'h1234;
    tick();
    wr_en = 0;
    chk("t5_data1", res_data, 32'h1234);
    chk("t5_addr1", res_addr, 3);
    tick(); tick();
    chk("t5_addr3", res_addr, 3);
    chk("t5_valid3", res_valid, 1);
    res_ready = 1;
    wait_done(cyc, 0);
    chk("t5_a0", g(0), 3);
    chk("t5_a1", g(1), 7);

    write(1, 32'hAA); write(2, 32'hAA); write(4, 32'hAA);
    res_ready = 0;
    issue(2'b00, 32'hAA, '1);
    tick();
    chk("t6_valid_pre", res_valid, 1);
    RST = 1;
    tick();
    RST = 0;
    chk("t6_valid", res_valid, 0);
    chk("t6_ready", cmd_ready, 1);
    res_ready = 1;
    issue(2'b00, 0, 0); wait_done(cyc, 0);
    chk("t6_count", got.size(), 0);
    chk("t6_none", none, 1);

    for (int i = 0; i < 30; i++) write($urandom_range(0, DEPTH + 9), $urandom_range(0, 7));
    for (int n = 0; n < 60; n++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        write($urandom_range(0, DEPTH + 9), $urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       mk = '0;
        1:       mk = '1;
        2:       mk = 7;
        3:       mk = 5;
        default: mk = $urandom;
      endcase
      res_ready = 1'($urandom_range(0, 1));
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 7), mk);
      wait_done(cyc, 1);
    end
    res_ready = 0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
